opb_master_arbiter: RTL and testbench
=====================================

Name: opb_master_arbiter

Overview:
- Shares the single OPB master port between two requesters.
  - M0: the UART command engine.
  - M1: the 2 kHz periodic status poller.
- Each requester issues one 32-bit read or write at a time through a REQ/ACK handshake.
- The arbiter serialises accesses with round-robin fairness and drives OPB_ADDR/OPB_DO/OPB_RE/OPB_WE.
- Read data is captured from OPB_DI after a fixed latency and returned with ACK.

Parameters:
RD_LATENCY, 2, cycles from the OPB_RE cycle to the cycle OPB_DI is valid; legal range 1..15.
ADDR_W, 32, OPB address width.
DATA_W, 32, OPB data width.

Ports:
SYS_CLK  in  1  system clock; all logic on rising edge.
SYS_RST  in  1  synchronous reset, active-low (0 = reset).
M0_REQ  in  1  requester 0 transaction request; held until M0_ACK.
M0_WR  in  1  1 = write, 0 = read; stable while M0_REQ high.
M0_ADDR  in  ADDR_W  requester 0 address.
M0_WDATA  in  DATA_W  requester 0 write data.
M0_ACK  out  1  one-cycle completion pulse to requester 0.
M0_RDATA  out  DATA_W  read data; valid in the M0_ACK cycle.
M1_REQ, M1_WR, M1_ADDR, M1_WDATA, M1_ACK, M1_RDATA: same as M0 for requester 1.
OPB_ADDR  out  ADDR_W  OPB address.
OPB_DO  out  DATA_W  OPB write data.
OPB_RE  out  1  OPB read strobe.
OPB_WE  out  1  OPB write strobe.
OPB_DI  in  DATA_W  OPB read data.
GRANT_ID  out  1  index of the currently or last granted requester.
BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (SYS_RST = 0 at a clock edge):
  - FSM goes to IDLE.
  - All outputs go to 0: ACKs, RDATAs, OPB_*, GRANT_ID, BUSY.
  - Round-robin pointer set so M0 wins the first tie.
  - Any in-flight transaction is abandoned; no ACK is issued for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If neither REQ is high, stay in IDLE.
  - If exactly one REQ is high, grant it.
  - If both are high, grant the requester not served last.
  - On grant: latch WR/ADDR/WDATA into internal registers, set GRANT_ID, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - OPB_ADDR and OPB_DO driven from the latched values.
  - OPB_WE = WR, OPB_RE = !WR.
  - Write: go to DONE. Read: clear the latency counter, go to WAIT.
- WAIT (reads only):
  - Counter increments each cycle; stays for RD_LATENCY cycles.
  - OPB_DI is captured into the read register at the end of the final WAIT cycle, i.e. the cycle ISSUE+RD_LATENCY.
  - Then go to DONE.
- DONE (exactly 1 cycle):
  - ACK of the granted requester = 1.
  - Its RDATA = the captured value for a read, 0 for a write.
  - Round-robin pointer updated to the served requester.
  - Go to IDLE.
- Outside ISSUE: OPB_ADDR, OPB_DO, OPB_RE and OPB_WE are driven to 0. RE and WE are never high together.
- Timing:
  - Write: REQ sampled in IDLE cycle t → WE in t+1 → ACK in t+2.
  - Read: REQ sampled in t → RE in t+1 → ACK in t+2+RD_LATENCY.
  - At least one IDLE cycle separates consecutive transactions.
- RDATA is registered. It holds its value after ACK until the next ACK to the same requester.
- Requester rules:
  - ADDR/WR/WDATA are sampled only at grant; changes after grant are ignored.
  - A requester may present a new transaction by keeping REQ high in the cycle after ACK. It is then arbitrated normally against the other requester.
- REQ dropped before ACK is a protocol violation. The latched transaction still completes and ACK is still pulsed.
- BUSY = 1 in ISSUE, WAIT and DONE.

Test Plan:
- Reset release, M0 write: M0_REQ=1, WR=1, ADDR=0x0000_0010, WDATA=0xDEAD_BEEF at t → OPB_WE=1, OPB_ADDR=0x10, OPB_DO=0xDEADBEEF in t+1 only; M0_ACK=1 in t+2; M0_RDATA=0.
- M1 read with RD_LATENCY=2: ADDR=0x24 at t; bench drives OPB_DI=0x1234_5678 only in t+3 → OPB_RE=1 in t+1; M1_ACK=1 in t+4; M1_RDATA=0x12345678.
- Both REQs high continuously from reset, both doing writes → grants alternate M0, M1, M0, M1; each ACK is 3 cycles after the previous one; no cycle has RE and WE together.
- M0 read in progress; SYS_RST=0 for one cycle during WAIT → no M0_ACK; all OPB outputs 0 next cycle; BUSY=0; the next simultaneous request grants M0.
- Addresses changed after grant: M0 ADDR changes from 0x40 to 0x80 in the ISSUE cycle → OPB_ADDR=0x40; ACK is still issued.
- RD_LATENCY=1 build: RE in t+1, OPB_DI sampled in t+2, ACK in t+3 with the sampled data.

Source files
------------

// File: rtl/opb_master_arbiter.sv
// OPB master arbiter: shares one OPB master port between the UART command
// engine (M0) and the periodic status poller (M1). One transaction at a time,
// round-robin on ties, fixed read latency from the OPB_RE cycle to OPB_DI.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no transaction; arbitrate REQs and latch the winner's request
// S_ISSUE | one cycle with OPB_ADDR/OPB_DO and OPB_RE or OPB_WE driven
// S_WAIT  | read only; count RD_LATENCY cycles, capture OPB_DI in the last
// S_DONE  | one-cycle ACK to the granted requester, update RR pointer
module opb_master_arbiter #(
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic              M0_REQ,
    input  logic              M0_WR,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic [DATA_W-1:0] M0_WDATA,
    output logic              M0_ACK,
    output logic [DATA_W-1:0] M0_RDATA,
    input  logic              M1_REQ,
    input  logic              M1_WR,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic [DATA_W-1:0] M1_WDATA,
    output logic              M1_ACK,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [ADDR_W-1:0] OPB_ADDR,
    output logic [DATA_W-1:0] OPB_DO,
    output logic              OPB_RE,
    output logic              OPB_WE,
    input  logic [DATA_W-1:0] OPB_DI,
    output logic              GRANT_ID,
    output logic              BUSY
);

    // Four bits cover the full 1..15 latency range.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic              r_wr;
    logic              r_gnt;
    logic              r_rr_last;
    logic              r_busy;
    logic              r_m0_ack;
    logic              r_m1_ack;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;
    logic [ADDR_W-1:0] r_opb_addr;
    logic [DATA_W-1:0] r_opb_do;
    logic              r_opb_re;
    logic              r_opb_we;

    logic              w_any_req;
    logic              w_sel;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_any_req   = M0_REQ | M1_REQ;
        w_sel       = (M0_REQ & M1_REQ) ? ~r_rr_last : M1_REQ;
        w_sel_wr    = w_sel ? M1_WR    : M0_WR;
        w_sel_addr  = w_sel ? M1_ADDR  : M0_ADDR;
        w_sel_wdata = w_sel ? M1_WDATA : M0_WDATA;
    end

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST) begin
            r_state    <= S_IDLE;
            r_lat_cnt  <= '0;
            r_wr       <= 1'b0;
            r_gnt      <= 1'b0;
            r_rr_last  <= 1'b1;   // M0 wins the first tie
            r_busy     <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_opb_addr <= '0;
            r_opb_do   <= '0;
            r_opb_re   <= 1'b0;
            r_opb_we   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= S_ISSUE;
                        r_gnt      <= w_sel;
                        r_wr       <= w_sel_wr;
                        r_opb_addr <= w_sel_addr;
                        r_opb_do   <= w_sel_wdata;
                        r_opb_we   <= w_sel_wr;
                        r_opb_re   <= ~w_sel_wr;
                        r_busy     <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    r_opb_addr <= '0;
                    r_opb_do   <= '0;
                    r_opb_re   <= 1'b0;
                    r_opb_we   <= 1'b0;
                    if (r_wr) begin
                        r_state <= S_DONE;
                        if (r_gnt) begin
                            r_m1_ack   <= 1'b1;
                            r_m1_rdata <= '0;
                        end else begin
                            r_m0_ack   <= 1'b1;
                            r_m0_rdata <= '0;
                        end
                    end else begin
                        r_state   <= S_WAIT;
                        r_lat_cnt <= '0;
                    end
                end

                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                    if (r_lat_cnt == LAT_LAST) begin
                        r_state <= S_DONE;
                        if (r_gnt) begin
                            r_m1_ack   <= 1'b1;
                            r_m1_rdata <= OPB_DI;
                        end else begin
                            r_m0_ack   <= 1'b1;
                            r_m0_rdata <= OPB_DI;
                        end
                    end
                end

                S_DONE: begin
                    r_m0_ack  <= 1'b0;
                    r_m1_ack  <= 1'b0;
                    r_rr_last <= r_gnt;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign M0_ACK   = r_m0_ack;
    assign M1_ACK   = r_m1_ack;
    assign M0_RDATA = r_m0_rdata;
    assign M1_RDATA = r_m1_rdata;
    assign OPB_ADDR = r_opb_addr;
    assign OPB_DO   = r_opb_do;
    assign OPB_RE   = r_opb_re;
    assign OPB_WE   = r_opb_we;
    assign GRANT_ID = r_gnt;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Bench for opb_master_arbiter: directed transactions push expected OPB strobes
// and ACK responses into queues; a negedge monitor pops and compares them.
module tb_opb_master_arbiter;

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0 (RD_LATENCY = 2) signals
    logic        a_m0_req, a_m0_wr, a_m1_req, a_m1_wr;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata, a_di;
    logic        a_m0_ack, a_m1_ack, a_re, a_we, a_gid, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_addr, a_do;

    // DUT 1 (RD_LATENCY = 1) signals
    logic        b_m0_req, b_m0_wr, b_m1_req, b_m1_wr;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata, b_di;
    logic        b_m0_ack, b_m1_ack, b_re, b_we, b_gid, b_busy;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_addr, b_do;

    opb_master_arbiter #(.RD_LATENCY(2)) u_dut0 (
        .SYS_CLK(clk), .SYS_RST(rst_n),
        .M0_REQ(a_m0_req), .M0_WR(a_m0_wr), .M0_ADDR(a_m0_addr), .M0_WDATA(a_m0_wdata),
        .M0_ACK(a_m0_ack), .M0_RDATA(a_m0_rdata),
        .M1_REQ(a_m1_req), .M1_WR(a_m1_wr), .M1_ADDR(a_m1_addr), .M1_WDATA(a_m1_wdata),
        .M1_ACK(a_m1_ack), .M1_RDATA(a_m1_rdata),
        .OPB_ADDR(a_addr), .OPB_DO(a_do), .OPB_RE(a_re), .OPB_WE(a_we), .OPB_DI(a_di),
        .GRANT_ID(a_gid), .BUSY(a_busy)
    );

    opb_master_arbiter #(.RD_LATENCY(1)) u_dut1 (
        .SYS_CLK(clk), .SYS_RST(rst_n),
        .M0_REQ(b_m0_req), .M0_WR(b_m0_wr), .M0_ADDR(b_m0_addr), .M0_WDATA(b_m0_wdata),
        .M0_ACK(b_m0_ack), .M0_RDATA(b_m0_rdata),
        .M1_REQ(b_m1_req), .M1_WR(b_m1_wr), .M1_ADDR(b_m1_addr), .M1_WDATA(b_m1_wdata),
        .M1_ACK(b_m1_ack), .M1_RDATA(b_m1_rdata),
        .OPB_ADDR(b_addr), .OPB_DO(b_do), .OPB_RE(b_re), .OPB_WE(b_we), .OPB_DI(b_di),
        .GRANT_ID(b_gid), .BUSY(b_busy)
    );

    typedef struct {
        int          cyc;
        bit          id;
        logic [31:0] rdata;
    } ack_exp_t;

    typedef struct {
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [31:0] dout;
    } opb_exp_t;

    ack_exp_t qa0[$];
    ack_exp_t qa1[$];
    opb_exp_t qo0[$];
    opb_exp_t qo1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ack(input int d, input int c, input bit id, input logic [31:0] rd);
        ack_exp_t e;
        e.cyc = c; e.id = id; e.rdata = rd;
        if (d == 0) qa0.push_back(e); else qa1.push_back(e);
    endtask

    task automatic exp_opb(input int d, input int c, input bit we, input logic [31:0] ad,
                           input logic [31:0] dt);
        opb_exp_t o;
        o.cyc = c; o.we = we; o.addr = ad; o.dout = dt;
        if (d == 0) qo0.push_back(o); else qo1.push_back(o);
    endtask

    task automatic mon(input int d, input logic m0a, input logic m1a, input logic gid,
                       input logic [31:0] r0, input logic [31:0] r1, input logic re,
                       input logic we, input logic [31:0] addr, input logic [31:0] dout);
        ack_exp_t e;
        opb_exp_t o;
        bit       have;
        if (m0a && m1a) chk($sformatf("dut%0d_dual_ack", d), 32'(m0a & m1a), 32'd0);
        for (int id = 0; id < 2; id++) begin
            logic a;
            a = (id == 1) ? m1a : m0a;
            if (a) begin
                have = (d == 0) ? (qa0.size() > 0) : (qa1.size() > 0);
                if (!have) begin
                    chk($sformatf("dut%0d_unexpected_ack_m%0d", d, id), 32'(a), 32'd0);
                end else begin
                    if (d == 0) e = qa0.pop_front(); else e = qa1.pop_front();
                    chk($sformatf("dut%0d_ack_cycle", d), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("dut%0d_ack_id", d), 32'(id), 32'(e.id));
                    chk($sformatf("dut%0d_grant_id", d), 32'(gid), 32'(e.id));
                    chk($sformatf("dut%0d_rdata_m%0d", d, id), (id == 1) ? r1 : r0, e.rdata);
                end
            end
        end
        if (re || we) begin
            chk($sformatf("dut%0d_re_we_together", d), 32'(re & we), 32'd0);
            have = (d == 0) ? (qo0.size() > 0) : (qo1.size() > 0);
            if (!have) begin
                chk($sformatf("dut%0d_unexpected_strobe", d), 32'(re | we), 32'd0);
            end else begin
                if (d == 0) o = qo0.pop_front(); else o = qo1.pop_front();
                chk($sformatf("dut%0d_strobe_cycle", d), 32'(cyc), 32'(o.cyc));
                chk($sformatf("dut%0d_opb_we", d), 32'(we), 32'(o.we));
                chk($sformatf("dut%0d_opb_re", d), 32'(re), 32'(!o.we));
                chk($sformatf("dut%0d_opb_addr", d), addr, o.addr);
                chk($sformatf("dut%0d_opb_do", d), dout, o.dout);
            end
        end else begin
            chk($sformatf("dut%0d_opb_idle_zero", d), addr | dout, 32'd0);
        end
    endtask

    // Monitor: sample both DUTs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        mon(0, a_m0_ack, a_m1_ack, a_gid, a_m0_rdata, a_m1_rdata, a_re, a_we, a_addr, a_do);
        mon(1, b_m0_ack, b_m1_ack, b_gid, b_m0_rdata, b_m1_rdata, b_re, b_we, b_addr, b_do);
    end

    task automatic chk_zero0(input string tag);
        chk({tag, "_busy"},  32'(a_busy), 32'd0);
        chk({tag, "_gid"},   32'(a_gid), 32'd0);
        chk({tag, "_acks"},  32'({a_m0_ack, a_m1_ack}), 32'd0);
        chk({tag, "_m0_rd"}, a_m0_rdata, 32'd0);
        chk({tag, "_m1_rd"}, a_m1_rdata, 32'd0);
        chk({tag, "_strb"},  32'({a_re, a_we}), 32'd0);
        chk({tag, "_addr"},  a_addr, 32'd0);
        chk({tag, "_do"},    a_do, 32'd0);
    endtask

    // M0 write whose ADDR/WDATA change in the ISSUE cycle; the latched values must win.
    task automatic m0_write_change(input logic [31:0] ad0, input logic [31:0] ad1,
                                   input logic [31:0] dt0, input logic [31:0] dt1);
        int t;
        t = cyc;
        a_m0_req = 1'b1; a_m0_wr = 1'b1; a_m0_addr = ad0; a_m0_wdata = dt0;
        exp_opb(0, t + 1, 1'b1, ad0, dt0);
        exp_ack(0, t + 2, 1'b0, 32'd0);
        next();
        a_m0_addr = ad1; a_m0_wdata = dt1;
        next();
        next();
        a_m0_req = 1'b0;
        next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected done", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        rst_n = 1'b0;
        a_m0_req = 0; a_m0_wr = 0; a_m0_addr = 0; a_m0_wdata = 0;
        a_m1_req = 0; a_m1_wr = 0; a_m1_addr = 0; a_m1_wdata = 0; a_di = JUNK;
        b_m0_req = 0; b_m0_wr = 0; b_m0_addr = 0; b_m0_wdata = 0;
        b_m1_req = 0; b_m1_wr = 0; b_m1_addr = 0; b_m1_wdata = 0; b_di = JUNK;
        repeat (3) next();
        chk_zero0("reset");
        chk("reset_dut1_busy", 32'(b_busy), 32'd0);
        rst_n = 1'b1;

        // M0 write right after reset release.
        next();
        t = cyc;
        a_m0_req = 1'b1; a_m0_wr = 1'b1; a_m0_addr = 32'h10; a_m0_wdata = 32'hDEAD_BEEF;
        exp_opb(0, t + 1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        exp_ack(0, t + 2, 1'b0, 32'd0);
        next();
        chk("s1_busy_issue", 32'(a_busy), 32'd1);
        next();
        next();
        a_m0_req = 1'b0;
        chk("s1_busy_idle", 32'(a_busy), 32'd0);
        repeat (2) next();

        // M1 read, OPB_DI valid only in t+3.
        t = cyc;
        a_m1_req = 1'b1; a_m1_wr = 1'b0; a_m1_addr = 32'h24; a_m1_wdata = 32'h0;
        exp_opb(0, t + 1, 1'b0, 32'h24, 32'h0);
        exp_ack(0, t + 4, 1'b1, 32'h1234_5678);
        next();
        next();
        next();
        a_di = 32'h1234_5678;
        next();
        a_di = JUNK;
        next();
        a_m1_req = 1'b0;
        repeat (2) next();

        // Address change after grant; M1_RDATA must hold its last read value.
        m0_write_change(32'h40, 32'h80, 32'h55, 32'h66);
        chk("rdata_hold_m1", a_m1_rdata, 32'h1234_5678);
        chk("rdata_write_m0", a_m0_rdata, 32'h0);

        // Both requesting writes continuously from a reset: M0, M1, M0, M1.
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        t = cyc;
        a_m0_req = 1'b1; a_m0_wr = 1'b1; a_m0_addr = 32'h100; a_m0_wdata = 32'hA0;
        a_m1_req = 1'b1; a_m1_wr = 1'b1; a_m1_addr = 32'h200; a_m1_wdata = 32'hB1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_opb(0, t + 1 + 3 * k, 1'b1, 32'h100, 32'hA0);
            else            exp_opb(0, t + 1 + 3 * k, 1'b1, 32'h200, 32'hB1);
            exp_ack(0, t + 2 + 3 * k, 1'(k % 2), 32'd0);
        end
        repeat (9) next();
        a_m0_req = 1'b0;
        repeat (3) next();
        a_m1_req = 1'b0;
        repeat (2) next();

        // Serve M0 last so the RR pointer must be restored by reset.
        m0_write_change(32'h44, 32'h88, 32'h77, 32'h99);

        // M0 read aborted by reset during WAIT.
        t = cyc;
        a_m0_req = 1'b1; a_m0_wr = 1'b0; a_m0_addr = 32'h30; a_m0_wdata = 32'h0;
        exp_opb(0, t + 1, 1'b0, 32'h30, 32'h0);
        next();
        next();
        rst_n = 1'b0;
        a_m0_req = 1'b0;
        next();
        chk_zero0("abort");
        rst_n = 1'b1;
        t = cyc;
        a_m0_req = 1'b1; a_m0_wr = 1'b1; a_m0_addr = 32'h300; a_m0_wdata = 32'h3;
        a_m1_req = 1'b1; a_m1_wr = 1'b1; a_m1_addr = 32'h400; a_m1_wdata = 32'h4;
        exp_opb(0, t + 1, 1'b1, 32'h300, 32'h3);
        exp_ack(0, t + 2, 1'b0, 32'd0);
        exp_opb(0, t + 4, 1'b1, 32'h400, 32'h4);
        exp_ack(0, t + 5, 1'b1, 32'd0);
        repeat (3) next();
        a_m0_req = 1'b0;
        repeat (3) next();
        a_m1_req = 1'b0;
        repeat (2) next();

        // RD_LATENCY = 1 build: M0 read then M1 write.
        t = cyc;
        b_m0_req = 1'b1; b_m0_wr = 1'b0; b_m0_addr = 32'h58; b_m0_wdata = 32'h0;
        exp_opb(1, t + 1, 1'b0, 32'h58, 32'h0);
        exp_ack(1, t + 3, 1'b0, 32'hCAFE_F00D);
        next();
        next();
        b_di = 32'hCAFE_F00D;
        next();
        b_di = JUNK;
        next();
        b_m0_req = 1'b0;
        next();
        t = cyc;
        b_m1_req = 1'b1; b_m1_wr = 1'b1; b_m1_addr = 32'h5C; b_m1_wdata = 32'h77;
        exp_opb(1, t + 1, 1'b1, 32'h5C, 32'h77);
        exp_ack(1, t + 2, 1'b1, 32'd0);
        repeat (3) next();
        b_m1_req = 1'b0;
        repeat (4) next();
        chk("dut1_rdata_hold_m0", b_m0_rdata, 32'hCAFE_F00D);

        chk("dut0_acks_outstanding",    32'(qa0.size()), 32'd0);
        chk("dut0_strobes_outstanding", 32'(qo0.size()), 32'd0);
        chk("dut1_acks_outstanding",    32'(qa1.size()), 32'd0);
        chk("dut1_strobes_outstanding", 32'(qo1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
